// File: rtl/mix_pkg.sv
// Shared MIX definitions: word/byte widths, F codes of the special group, and
// the sequencer state and unit encodings.
package mix_pkg;

  localparam int WORD_W = 30;
  localparam int BYTE_W = 6;

  localparam logic [BYTE_W-1:0] F_NUM  = 6'd0;
  localparam logic [BYTE_W-1:0] F_CHAR = 6'd1;
  localparam logic [BYTE_W-1:0] F_HLT  = 6'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_HALTED = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    U_NUM  = 2'd0,
    U_CHAR = 2'd1,
    U_HLT  = 2'd2,
    U_BAD  = 2'd3
  } unit_t;

  function automatic unit_t decode_f(input logic [BYTE_W-1:0] f);
    case (f)
      F_NUM:   return U_NUM;
      F_CHAR:  return U_CHAR;
      F_HLT:   return U_HLT;
      default: return U_BAD;
    endcase
  endfunction

endpackage

// File: rtl/special_cnt.sv
// Timing counters for special_seq: execution-time pad (EXEC_UNITS) and, when
// SPECIAL_WDOG_EN is defined, the WAIT_MAX watchdog on the unit's done.
module special_cnt #(
  parameter int EXEC_UNITS = 10
`ifdef SPECIAL_WDOG_EN
  , parameter int WAIT_MAX = 64
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
`ifdef SPECIAL_WDOG_EN
  input  logic in_wait,
`endif
  output logic pad_ok,
  output logic wd_expired
);

  localparam int PAD_MAX = (EXEC_UNITS > 1) ? EXEC_UNITS - 1 : 0;
  localparam int PW      = $clog2(PAD_MAX + 2);

  // Holds the number of cycles elapsed since the start cycle; saturates.
  logic [PW-1:0] pad_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values and the order of statements never changes behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_cnt <= '0;
    end else if (clr) begin
      pad_cnt <= PW'(1);
    end else if (pad_cnt < PW'(PAD_MAX)) begin
      pad_cnt <= pad_cnt + 1'b1;
    end
  end

  assign pad_ok = (pad_cnt >= PW'(PAD_MAX));

`ifdef SPECIAL_WDOG_EN
  localparam int WW = $clog2(WAIT_MAX + 1);

  logic [WW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (clr) begin
      wd_cnt <= '0;
    end else if (in_wait && (wd_cnt != WW'(WAIT_MAX - 1))) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expired = in_wait && (wd_cnt == WW'(WAIT_MAX - 1));
`else
  assign wd_expired = 1'b0;
`endif

endmodule

// File: rtl/special_seq.sv
// Sequencer for MIX opcode 5 (NUM/CHAR/HLT): launches the unit, pads to
// EXEC_UNITS, writes results back. SPECIAL_WDOG_EN adds a WAIT_MAX watchdog.
module special_seq
  import mix_pkg::*;
#(
  parameter int EXEC_UNITS = 10
`ifdef SPECIAL_WDOG_EN
  , parameter int WAIT_MAX = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BYTE_W-1:0]     field,
  input  logic [WORD_W-1:0]     ra_in,
  input  logic [WORD_W-1:0]     rx_in,
  input  logic                  go,
  output logic                  num_start,
  output logic [2*WORD_W-1:0]   num_in,
  input  logic [WORD_W-1:0]     num_out,
  input  logic                  num_ovf,
  input  logic                  num_done,
  output logic                  char_start,
  output logic [WORD_W-1:0]     char_in,
  input  logic [2*WORD_W-1:0]   char_out,
  input  logic                  char_done,
  output logic                  hlt_start,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_a,
  output logic                  wr_x,
  output logic [WORD_W-1:0]     a_out,
  output logic [WORD_W-1:0]     x_out,
  output logic                  ovf_set,
  output logic                  halted,
  output logic                  err
);

  state_t            state;
  unit_t             unit;
  logic [WORD_W-1:0] ra_q, rx_q;
  logic [WORD_W-1:0] res_a, res_x;
  logic              res_ovf;
  logic              seen;

  logic              accept, done_now, pad_ok, wd_expired;
  logic [WORD_W-1:0] live_a, live_x;
  logic              live_ovf;

  assign accept   = (state == S_IDLE) && start;
  assign done_now = (state == S_WAIT) &&
                    (((unit == U_NUM) && num_done) || ((unit == U_CHAR) && char_done));
  assign live_a   = (unit == U_CHAR) ? char_out[2*WORD_W-1:WORD_W] : num_out;
  assign live_x   = char_out[WORD_W-1:0];
  assign live_ovf = (unit == U_NUM) && num_ovf;

  // Operands stay on the unit buses from launch until the next accepted start.
  assign num_in  = {ra_q, rx_q};
  assign char_in = ra_q;

  special_cnt #(
    .EXEC_UNITS (EXEC_UNITS)
`ifdef SPECIAL_WDOG_EN
    , .WAIT_MAX (WAIT_MAX)
`endif
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept),
`ifdef SPECIAL_WDOG_EN
    .in_wait    (state == S_WAIT),
`endif
    .pad_ok     (pad_ok),
    .wd_expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and result registers are reset too, so an aborted
      // operation leaves nothing stale on the unit buses or write-back data.
      state      <= S_IDLE;
      unit       <= U_NUM;
      ra_q       <= '0;
      rx_q       <= '0;
      res_a      <= '0;
      res_x      <= '0;
      res_ovf    <= 1'b0;
      seen       <= 1'b0;
      num_start  <= 1'b0;
      char_start <= 1'b0;
      hlt_start  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_a       <= 1'b0;
      wr_x       <= 1'b0;
      a_out      <= '0;
      x_out      <= '0;
      ovf_set    <= 1'b0;
      halted     <= 1'b0;
      err        <= 1'b0;
    end else begin
      // NOTE: every pulse output gets a default here, so each state only
      // states when a pulse fires and no branch can leave a stale value.
      num_start  <= 1'b0;
      char_start <= 1'b0;
      hlt_start  <= 1'b0;
      done       <= 1'b0;
      wr_a       <= 1'b0;
      wr_x       <= 1'b0;
      ovf_set    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            ra_q <= ra_in;
            rx_q <= rx_in;
            unit <= decode_f(field);
            busy <= 1'b1;
            seen <= 1'b0;
            case (decode_f(field))
              U_NUM:  begin num_start  <= 1'b1; state <= S_LAUNCH; end
              U_CHAR: begin char_start <= 1'b1; state <= S_LAUNCH; end
              U_HLT:  begin hlt_start  <= 1'b1; state <= S_LAUNCH; end
              default: begin
                err   <= 1'b1;
                done  <= 1'b1;
                state <= S_ERR;
              end
            endcase
          end
        end

        S_LAUNCH: begin
          if (unit == U_HLT) begin
            halted <= 1'b1;
            state  <= S_HALTED;
          end else begin
            state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          // The result is taken on the unit's done cycle; padding may follow.
          if (done_now && !seen) begin
            seen    <= 1'b1;
            res_a   <= live_a;
            res_x   <= live_x;
            res_ovf <= live_ovf;
          end
          if ((seen || done_now) && pad_ok) begin
            wr_a    <= 1'b1;
            wr_x    <= (unit == U_CHAR);
            a_out   <= seen ? res_a : live_a;
            x_out   <= seen ? res_x : live_x;
            ovf_set <= seen ? res_ovf : live_ovf;
            done    <= 1'b1;
            state   <= S_WRITE;
          end else if (wd_expired && !seen && !done_now) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_ERR;
          end
        end

        S_HALTED: begin
          if (go) begin
            halted <= 1'b0;
            done   <= 1'b1;
            state  <= S_WRITE;
          end
        end

        S_WRITE, S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_special_seq.sv
// Randomized scoreboard bench for special_seq: a driver queues expected
// completions, a monitor pops and compares them whenever done is seen.
module tb_special_seq;

  localparam int EXEC_UNITS = 10;
`ifdef SPECIAL_WDOG_EN
  localparam int WAIT_MAX = 64;
`endif
  localparam int OP_BOUND = 300;

  logic        clk, rst_n, start, go;
  logic [5:0]  field;
  logic [29:0] ra_in, rx_in, num_out;
  logic        num_ovf, num_done, char_done;
  logic [59:0] char_out;
  logic        num_start, char_start, hlt_start, busy, done;
  logic        wr_a, wr_x, ovf_set, halted, err;
  logic [59:0] num_in;
  logic [29:0] char_in, a_out, x_out;

  special_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .field(field),
    .ra_in(ra_in), .rx_in(rx_in), .go(go),
    .num_start(num_start), .num_in(num_in), .num_out(num_out),
    .num_ovf(num_ovf), .num_done(num_done),
    .char_start(char_start), .char_in(char_in), .char_out(char_out),
    .char_done(char_done), .hlt_start(hlt_start),
    .busy(busy), .done(done), .wr_a(wr_a), .wr_x(wr_x),
    .a_out(a_out), .x_out(x_out), .ovf_set(ovf_set),
    .halted(halted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
  endtask

  // One expected completion: write-back, flags, cycle of done, launched unit.
  typedef struct {
    bit          wa;
    bit          wx;
    logic [29:0] a;
    logic [29:0] x;
    bit          ovf;
    bit          err;
    int          cyc;
    int          unit;
  } exp_t;

  exp_t sb[$];

  // Unit-model knobs, set by the driver before each start.
  int          num_lat, char_lat;
  logic [29:0] num_val;
  logic        num_ovf_v;
  logic [59:0] char_val;
  logic [59:0] exp_ops;
  bit          spur;
  bit          num_mute;
  bit          err_model;

  // NUM unit model; also fires a stray num_done during CHAR ops.
  initial begin
    num_done = 1'b0; num_out = '0; num_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (num_start) begin
        check("num_in", num_in, exp_ops);
        if (!num_mute) begin
          repeat (num_lat) @(posedge clk);
          #1 num_done = 1'b1; num_out = num_val; num_ovf = num_ovf_v;
          @(posedge clk);
          #1 num_done = 1'b0; num_out = 30'($urandom); num_ovf = 1'b1;
        end
      end else if (char_start && spur) begin
        repeat (2) @(posedge clk);
        #1 num_done = 1'b1; num_out = 30'($urandom); num_ovf = 1'b1;
        @(posedge clk);
        #1 num_done = 1'b0;
      end
    end
  end

  // CHAR unit model; also fires a stray char_done during NUM ops.
  initial begin
    char_done = 1'b0; char_out = '0;
    forever begin
      @(negedge clk);
      if (char_start) begin
        check("char_in", char_in, exp_ops[59:30]);
        repeat (char_lat) @(posedge clk);
        #1 char_done = 1'b1; char_out = char_val;
        @(posedge clk);
        #1 char_done = 1'b0; char_out = {28'($urandom), 32'($urandom)};
      end else if (num_start && spur) begin
        repeat (2) @(posedge clk);
        #1 char_done = 1'b1; char_out = {28'($urandom), 32'($urandom)};
        @(posedge clk);
        #1 char_done = 1'b0;
      end
    end
  end

  // Monitor: counts unit launches and checks each done against the scoreboard.
  int n_num = 0, n_char = 0, n_hlt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (num_start)  n_num++;
      if (char_start) n_char++;
      if (hlt_start)  n_hlt++;
      if (!done && (wr_a || wr_x || ovf_set)) fail("write_without_done");
      if (done) begin
        if (sb.size() == 0) begin
          fail("unexpected_done");
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("wr_a", wr_a, e.wa);
          check("wr_x", wr_x, e.wx);
          check("ovf_set", ovf_set, e.ovf);
          check("err", err, e.err);
          if (e.wa) check("a_out", a_out, e.a);
          if (e.wx) check("x_out", x_out, e.x);
          check("unit_starts", n_num * 100 + n_char * 10 + n_hlt,
                (e.unit == 0) ? 100 : (e.unit == 1) ? 10 : (e.unit == 2) ? 1 : 0);
          n_num = 0; n_char = 0; n_hlt = 0;
        end
      end
    end
  end

  // Issue one NUM/CHAR/illegal op; optionally poke start/go while busy.
  task automatic do_op(input logic [5:0] f, input logic [29:0] ra, input logic [29:0] rx,
                       input int lat, input logic [59:0] res, input logic ovf, input bit junk);
    exp_t e;
    int   s, d, jc, guard;
    num_lat = lat; char_lat = lat;
    num_val = res[29:0]; num_ovf_v = ovf; char_val = res;
    exp_ops = {ra, rx};
    spur = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start = 1'b1; field = f; ra_in = ra; rx_in = rx; s = cyc;
    e = '{default: 0};
    if (f == 6'd0) begin
      e.wa = 1; e.a = res[29:0]; e.ovf = ovf; e.unit = 0;
      d = s + ((lat + 2 > EXEC_UNITS) ? lat + 2 : EXEC_UNITS);
`ifdef SPECIAL_WDOG_EN
      if (num_mute) begin
        e.wa = 0; e.ovf = 0; err_model = 1'b1;
        d = s + 2 + WAIT_MAX;
      end
`endif
    end else if (f == 6'd1) begin
      e.wa = 1; e.wx = 1; e.a = res[59:30]; e.x = res[29:0]; e.unit = 1;
      d = s + ((lat + 2 > EXEC_UNITS) ? lat + 2 : EXEC_UNITS);
    end else begin
      err_model = 1'b1; e.unit = 3;
      d = s + 1;
    end
    e.err = err_model;
    e.cyc = d;
    sb.push_back(e);
    jc = $urandom_range(d, s + 1);
    guard = 0;
    forever begin
      @(posedge clk); #1;
      start = 1'b0; go = 1'b0;
      if (sb.size() == 0) break;
      if (junk && cyc == jc) begin
        start = 1'b1; go = 1'b1; field = 6'($urandom);
      end
      if (guard == 0) begin
        @(negedge clk);
        check("busy_launch", busy, 1'b1);
      end
      guard++;
      if (guard > OP_BOUND) begin
        fail("op_timeout");
        sb.delete();
        break;
      end
    end
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic wait_empty();
    int guard = 0;
    while (sb.size() != 0) begin
      @(posedge clk); #1;
      guard++;
      if (guard > OP_BOUND) begin
        fail("wait_timeout");
        sb.delete();
      end
    end
  endtask

  task automatic do_hlt();
    exp_t e;
    int   s, g;
    exp_ops = {30'($urandom), 30'($urandom)};
    spur = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; field = 6'd2; ra_in = exp_ops[59:30]; rx_in = exp_ops[29:0]; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check("halted_cycle", cyc, s + 2);
    repeat (3) begin
      @(posedge clk); #1;
      start = 1'b1; field = 6'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("halted_hold", {halted, busy}, 2'b11);
    @(posedge clk); #1;
    go = 1'b1; g = cyc;
    e = '{default: 0};
    e.unit = 2; e.err = err_model; e.cyc = g + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    go = 1'b0;
    wait_empty();
    @(negedge clk);
    check("halt_release", {halted, busy}, 2'b00);
  endtask

  task automatic rand_op(input bit allow_bad);
    int k = $urandom_range(0, 9);
    logic [59:0] r = {28'($urandom), 32'($urandom)};
    if (k == 8) do_hlt();
    else if (k == 9 && allow_bad)
      do_op(6'($urandom_range(3, 63)), 30'($urandom), 30'($urandom), 1, r, 1'b0, 1'b1);
    else
      do_op((k < 4 || k == 9) ? 6'd0 : 6'd1, 30'($urandom), 30'($urandom),
            $urandom_range(1, 20), r, 1'($urandom), 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; go = 1'b0; field = '0; ra_in = '0; rx_in = '0;
    num_lat = 1; char_lat = 1; num_val = '0; num_ovf_v = 1'b0; char_val = '0;
    exp_ops = '0; spur = 1'b0; num_mute = 1'b0; err_model = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {num_start, char_start, hlt_start, busy, done,
                         wr_a, wr_x, ovf_set, halted, err}, 10'd0);
    check("reset_num_in", num_in, 60'd0);
    check("reset_wb_data", {a_out, x_out}, 60'd0);
    @(negedge clk) rst_n = 1'b1;

    // Directed NUM, CHAR, HLT.
    do_op(6'd0, 30'o0012131415, 30'o1617202100, 3, {30'd0, 30'd12345678}, 1'b0, 1'b0);
    do_op(6'd1, 30'd255, 30'($urandom), 5, 60'h123456789ABCDEF, 1'b0, 1'b0);
    do_hlt();
    // Long unit latency: done is set by the unit, not the pad.
    do_op(6'd0, 30'($urandom), 30'($urandom), 17, {30'd0, 30'h2AAAAAAA}, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) rand_op(1'b0);

    // Illegal F, then err must remain set through later operations.
    do_op(6'd7, 30'($urandom), 30'($urandom), 1, 60'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) rand_op(1'b1);

`ifdef SPECIAL_WDOG_EN
    num_mute = 1'b1;
    do_op(6'd0, 30'($urandom), 30'($urandom), 5, 60'd0, 1'b0, 1'b0);
    num_mute = 1'b0;
`endif

    // Abort: reset during WAIT; the late num_done must cause nothing.
    num_lat = 30; spur = 1'b0; num_val = 30'h3FFFFFFF; num_ovf_v = 1'b1;
    exp_ops = {30'd99, 30'd77};
    @(posedge clk); #1;
    start = 1'b1; field = 6'd0; ra_in = 30'd99; rx_in = 30'd77;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_ctrl", {num_start, char_start, hlt_start, busy, done,
                         wr_a, wr_x, ovf_set, halted, err}, 10'd0);
    check("abort_num_in", num_in, 60'd0);
    err_model = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    check("abort_idle", {busy, err}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
